cpu_iob_bridge: RTL and testbench

Parametrised bridge between the pipelined CPU data-memory port and the IOB bus. It replaces the single-word, address-gated memory adapter. New behaviour:
- sub-word loads and stores, with byte-lane steering and sign/zero extension;
- an explicit CPU stall;
- a split IOB address phase and read-data phase;
- misalignment detection;
- an optional bus timeout.

It sits between the CPU memory stage and the system IOB interconnect.

---
 rtl/cpu_iob_bridge.sv | 177 +++++++++++++++++
 tb/tb_cpu_iob_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_iob_bridge.sv
// CPU memory-stage to IOB bridge: sub-word steering, sign/zero extension, stall and misalignment errors.
// Optional bus timeout is compiled in when CPU_IOB_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps

// Handshake: iob_valid_o rises together with iob_addr_o/iob_wdata_o/iob_wstrb_o and all four hold
// until the edge that samples iob_ready_i=1; read data is taken only on iob_rvalid_i while in RESP.
module cpu_iob_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [2:0]        cpu_funct3_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              cpu_err_o,
  output logic              iob_valid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0] iob_wdata_o,
  output logic [3:0]        iob_wstrb_o,
  input  logic              iob_ready_i,
  input  logic              iob_rvalid_i,
  input  logic [DATA_W-1:0] iob_rdata_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  if (ADDR_W < 3 || DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cpu_iob_bridge: unsupported parameter set");
  end

  state_t            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;

  logic [1:0]        req_off;
  logic              req_illegal;
  logic [3:0]        req_strb;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_ext;

  assign req_off = cpu_addr_i[1:0];

  // Store steering and legality are decided from the live request, only used in IDLE.
  always_comb begin
    req_illegal = 1'b0;
    req_strb    = 4'b1111;
    req_wdata   = cpu_wdata_i;
    case (cpu_funct3_i)
      3'd0, 3'd4: begin
        req_strb  = 4'b0001 << req_off;
        req_wdata = {4{cpu_wdata_i[7:0]}};
      end
      3'd1, 3'd5: begin
        req_strb    = 4'b0011 << req_off;
        req_wdata   = {2{cpu_wdata_i[15:0]}};
        req_illegal = req_off[0];
      end
      3'd2:    req_illegal = (req_off != 2'b00);
      default: req_illegal = 1'b1;
    endcase
    if (cpu_we_i && cpu_funct3_i[2]) req_illegal = 1'b1;
  end

  assign rd_shift = iob_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'd0:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd1:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    rd_ext = {24'd0, rd_shift[7:0]};
      3'd5:    rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        to_hit;
  // ">=" keeps the abort armed in RESP even when REQ used up the whole budget.
  assign to_hit = (to_cnt >= 32'(TIMEOUT_CYCLES - 1));
`endif

  assign cpu_stall_o = cpu_req_i & (state != ST_DONE);
  assign dbg_state_o = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      iob_valid_o <= 1'b0;
      iob_addr_o  <= '0;
      iob_wdata_o <= '0;
      iob_wstrb_o <= 4'd0;
      cpu_rdata_o <= '0;
      cpu_err_o   <= 1'b0;
`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
      if (state == ST_REQ || state == ST_RESP) to_cnt <= to_cnt + 32'd1;
`endif
      case (state)
        ST_IDLE: begin
          if (cpu_req_i) begin
            we_q     <= cpu_we_i;
            funct3_q <= cpu_funct3_i;
            off_q    <= req_off;
            if (req_illegal) begin
              state       <= ST_DONE;
              cpu_err_o   <= 1'b1;
              cpu_rdata_o <= '0;
            end else begin
              state       <= ST_REQ;
              iob_valid_o <= 1'b1;
              iob_addr_o  <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
              iob_wdata_o <= req_wdata;
              iob_wstrb_o <= cpu_we_i ? req_strb : 4'b0000;
`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
              to_cnt      <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (iob_ready_i) begin
            iob_valid_o <= 1'b0;
            state       <= we_q ? ST_DONE : ST_RESP;
          end
`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
          else if (to_hit) begin
            iob_valid_o <= 1'b0;
            state       <= ST_DONE;
            cpu_err_o   <= 1'b1;
            cpu_rdata_o <= '0;
          end
`endif
        end
        ST_RESP: begin
          if (iob_rvalid_i) begin
            cpu_rdata_o <= rd_ext;
            state       <= ST_DONE;
          end
`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
          else if (to_hit) begin
            state       <= ST_DONE;
            cpu_err_o   <= 1'b1;
            cpu_rdata_o <= '0;
          end
`endif
        end
        ST_DONE: begin
          cpu_err_o <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_iob_bridge.sv
// Randomised scoreboard bench for cpu_iob_bridge: driver pushes expected bus and CPU responses,
// a negedge monitor pops and compares them against what the bridge presents.
`timescale 1ns/1ps

module tb_cpu_iob_bridge;

`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  localparam int N_RAND = 120;

  logic        clk, reset_n;
  logic        cpu_req_i, cpu_we_i;
  logic [2:0]  cpu_funct3_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_stall_o, cpu_err_o;
  logic        iob_valid_o;
  logic [31:0] iob_addr_o, iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_ready_i, iob_rvalid_i;
  logic [31:0] iob_rdata_i;
  logic [1:0]  dbg_state;

  cpu_iob_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_funct3_i(cpu_funct3_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_stall_o(cpu_stall_o), .cpu_err_o(cpu_err_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
    .iob_rdata_i(iob_rdata_i), .dbg_state_o(dbg_state)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        chk_wd;
  } aph_t;

  typedef struct packed {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    logic [31:0] done_cyc;
  } cpl_t;

  aph_t aph_q[$];
  cpl_t cpl_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          mon_en   = 0;
  int          bus_rdy_delay, bus_rv_delay;
  logic [31:0] bus_word;
  bit          bus_is_read;

  // clock / reset / cycle counter
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_fail++;
    finish_test();
  end

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // IOB slave: ready after bus_rdy_delay cycles of valid, rvalid bus_rv_delay cycles after ready;
  // stray ready/rvalid pulses are sprinkled where the bridge must ignore them.
  initial begin
    int wait_n;
    int rv_cnt;
    bit pend;
    wait_n = 0; rv_cnt = 0; pend = 0;
    iob_ready_i = 0; iob_rvalid_i = 0; iob_rdata_i = 0;
    forever begin
      @(negedge clk);
      iob_ready_i  = 0;
      iob_rvalid_i = 0;
      iob_rdata_i  = $urandom();
      if (pend) begin
        if (rv_cnt >= bus_rv_delay) begin
          iob_rvalid_i = 1;
          iob_rdata_i  = bus_word;
          pend = 0;
        end else rv_cnt++;
      end else begin
        if (iob_valid_o) begin
          if (wait_n >= bus_rdy_delay) begin
            iob_ready_i = 1;
            wait_n = 0;
            if (bus_is_read) begin
              pend = 1;
              rv_cnt = 0;
            end
          end else wait_n++;
        end else begin
          wait_n = 0;
          if ($urandom_range(0, 3) == 0) iob_ready_i = 1;
        end
        if ($urandom_range(0, 3) == 0) iob_rvalid_i = 1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    aph_t a;
    cpl_t c;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (iob_valid_o && iob_ready_i) begin
          if (aph_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL iob_unexpected: got valid addr 0x%08h required no bus access at cycle %0d", iob_addr_o, cyc);
          end else begin
            a = aph_q.pop_front();
            check32("iob_addr", iob_addr_o, a.addr);
            check32("iob_wstrb", 32'(iob_wstrb_o), 32'(a.strb));
            if (a.chk_wd) check32("iob_wdata", iob_wdata_o, a.wdata);
          end
        end
        if (cpu_req_i && !cpu_stall_o) begin
          if (cpl_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cpu_unexpected_done: got stall 0 required stall 1 at cycle %0d", cyc);
          end else begin
            c = cpl_q.pop_front();
            check32("done_cycle", cyc, c.done_cyc);
            check32("cpu_err", 32'(cpu_err_o), 32'(c.err));
            check32("valid_in_done", 32'(iob_valid_o), 32'd0);
            if (c.chk_rd) check32("cpu_rdata", cpu_rdata_o, c.rdata);
          end
        end else begin
          check32("err_outside_done", 32'(cpu_err_o), 32'd0);
        end
      end
    end
  end

  // driver: one CPU access, expectations computed from the access rules
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] word,
                           input int rd, input int rv, input bit keep, input bit exp_to);
    aph_t        a;
    cpl_t        c;
    int          sz;
    int          c0;
    int          n;
    bit          illegal;
    logic [31:0] v;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    if (addr % sz != 0) illegal = 1;
    c0 = cyc;
    bus_rdy_delay = rd;
    bus_rv_delay  = rv;
    bus_word      = word;
    bus_is_read   = !we;
    if (!illegal && !exp_to) begin
      a.addr   = addr & ~32'd3;
      a.strb   = we ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'd0;
      a.wdata  = (sz == 1) ? wd[7:0] * 32'h01010101 : (sz == 2) ? wd[15:0] * 32'h00010001 : wd;
      a.chk_wd = we;
      aph_q.push_back(a);
    end
    c.err    = illegal || exp_to;
    c.chk_rd = illegal || exp_to || !we;
    c.rdata  = 0;
    if (illegal) c.done_cyc = c0 + 1;
    else if (exp_to) c.done_cyc = c0 + 1 + TO;
    else if (we) c.done_cyc = c0 + 2 + rd;
    else begin
      v = word >> (8 * (addr % 4));
      if (sz == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end else if (sz == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      c.rdata    = v;
      c.done_cyc = c0 + 3 + rd + rv;
    end
    cpl_q.push_back(c);
    cpu_req_i = 1; cpu_we_i = we; cpu_funct3_i = f3; cpu_addr_i = addr; cpu_wdata_i = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall_o) break;
      n++;
      if (n > 300) begin
        n_fail++;
        $display("FAIL stall_bound: got stall still 1 after %0d cycles required completion", n);
        finish_test();
      end
      @(posedge clk);
      #1;
      // request fields must be ignored once the access is captured
      cpu_we_i     = 1'($urandom_range(0, 1));
      cpu_funct3_i = 3'($urandom_range(0, 7));
      cpu_addr_i   = $urandom();
      cpu_wdata_i  = $urandom();
    end
    @(posedge clk);
    #1;
    if (!keep) cpu_req_i = 0;
  endtask

  task automatic check_cleared(input string tag);
    check32({tag, "_valid"}, 32'(iob_valid_o), 32'd0);
    check32({tag, "_addr"}, iob_addr_o, 32'd0);
    check32({tag, "_wdata"}, iob_wdata_o, 32'd0);
    check32({tag, "_wstrb"}, 32'(iob_wstrb_o), 32'd0);
    check32({tag, "_rdata"}, cpu_rdata_o, 32'd0);
    check32({tag, "_err"}, 32'(cpu_err_o), 32'd0);
    check32({tag, "_stall"}, 32'(cpu_stall_o), 32'd0);
  endtask

  task automatic reset_mid_read();
    aph_t a;
    bus_rdy_delay = 0; bus_rv_delay = 6; bus_word = 32'hCAFEF00D; bus_is_read = 1;
    a.addr = 32'h4000; a.wdata = 0; a.strb = 0; a.chk_wd = 0;
    aph_q.push_back(a);
    cpu_req_i = 1; cpu_we_i = 0; cpu_funct3_i = 3'd2; cpu_addr_i = 32'h4000; cpu_wdata_i = 32'h13572468;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n   = 0;
    cpu_req_i = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    @(negedge clk);
    check_cleared("rst_mid");
    repeat (10) @(negedge clk);
    check_cleared("late_rvalid");
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          k;
    bit          keep;
    reset_n = 0; cpu_req_i = 0; cpu_we_i = 0; cpu_funct3_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    bus_rdy_delay = 0; bus_rv_delay = 0; bus_word = 0; bus_is_read = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk);
    #1;
    reset_n = 1;
    mon_en  = 1;
    @(posedge clk);
    #1;

    do_access(1, 3'd2, 32'h1004, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0);
    do_access(1, 3'd0, 32'h2003, 32'h000000A5, 32'h0, 1, 0, 0, 0);
    do_access(0, 3'd0, 32'h2003, $urandom(), 32'h80F07F01, 0, 0, 1, 0);
    do_access(0, 3'd5, 32'h2002, $urandom(), 32'h80F07F01, 0, 3, 0, 0);
    reset_mid_read();
    do_access(0, 3'd1, 32'h5002, $urandom(), 32'h1234ABCD, 1, 1, 1, 0);
    do_access(0, 3'd2, 32'h3002, $urandom(), 32'h0, 0, 0, 1, 0);
    do_access(1, 3'd4, 32'h2000, $urandom(), 32'h0, 0, 0, 0, 0);
`ifdef CPU_IOB_BRIDGE_TIMEOUT_EN
    do_access(1, 3'd2, 32'h6000, 32'h11112222, 32'h0, 1000, 0, 0, 1);
    do_access(1, 3'd2, 32'h6004, 32'h33334444, 32'h0, TO - 1, 0, 0, 0);
`endif

    for (int i = 0; i < N_RAND; i++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin
        k  = $urandom_range(0, 4);
        f3 = 3'((k > 2) ? k + 1 : k);
      end
      addr = $urandom() & ~32'd3;
      if ($urandom_range(0, 1) == 0) addr = addr + 32'($urandom_range(0, 3));
      keep = (i != N_RAND - 1) && ($urandom_range(0, 1) == 1);
      do_access(we, f3, addr, $urandom(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), keep, 0);
      if (!keep) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    repeat (3) @(posedge clk);
    check32("aph_q_empty", 32'(aph_q.size()), 32'd0);
    check32("cpl_q_empty", 32'(cpl_q.size()), 32'd0);
    finish_test();
  end

endmodule
